handshake_rr_arbiter: RTL and testbench

- Shares one valid-ready consumer channel among N producer channels using round-robin arbitration.
- Registered output stage gives a 1-cycle latency at full throughput (one beat per cycle).
- Sits in front of shared resources such as a CDB port, a memory request port or a functional-unit issue slot.
- Reports which requester won each beat so downstream logic can route the response.

---
 rtl/handshake_rr_arbiter_pkg.sv | 20 ++
 rtl/handshake_rr_arbiter_if.sv | 43 ++++
 rtl/handshake_rr_arbiter_rr_pick.sv | 46 ++++
 rtl/handshake_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_handshake_rr_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared definitions for the round-robin handshake arbiter: index sizing helper,
// requester limit and a maximum-width index type.
package handshake_arb_pkg;

  localparam int MAX_REQ = 32;

  // Index width for MAX_REQ requesters (clog2(32) = 5).
  typedef logic [4:0] arb_idx_t;

  // ceil(log2(n)) but never below 1, so a single-requester build still has a 1-bit index.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((32'sd1 <<< w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter_if.sv
// Handshake bundle between N producers, the arbiter and one consumer.
// The arbiter uses the slave modport; the producer/consumer side uses master.
interface handshake_rr_arbiter_if
  import handshake_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);

  localparam int IDX_W = clog2_min1(NUM_REQ);

  logic [NUM_REQ-1:0]            in_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]            in_last;
  logic [NUM_REQ-1:0]            in_ready;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [IDX_W-1:0]              out_src;
  logic                          out_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_src
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_src
  );

endinterface

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Rotated priority encoder: the first set bit of req at or after ptr wins,
// wrapping modulo NUM_REQ.
module rr_pick
  import handshake_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  int sum_s;
  int pos_s;

  // Scan from the farthest slot back to ptr so the nearest valid requester is the last writer.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    sum_s   = 0;
    pos_s   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum_s = int'(ptr) + k;
      pos_s = (sum_s >= NUM_REQ) ? (sum_s - NUM_REQ) : sum_s;
      if (req[pos_s]) begin
        gnt_idx = IDX_W'(pos_s);
        any     = 1'b1;
      end else begin
        gnt_idx = gnt_idx;
        any     = any;
      end
    end
  end

  // Expand the winning index into a one-hot grant vector.
  always_comb begin
    gnt_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_onehot[i] = any && (gnt_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// N-to-1 round-robin valid/ready arbiter with a registered output stage.
// Optional packet locking (multi-beat packets stay contiguous) with HS_ARB_PKT_LOCK_EN.
module handshake_rr_arbiter
  import handshake_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  handshake_rr_arbiter_if.slave   bus
);

  localparam int IDX_W = clog2_min1(NUM_REQ);

  logic [IDX_W-1:0]      rr_ptr_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [IDX_W-1:0]      out_src_r;

  logic [NUM_REQ-1:0]    pick_onehot_s;
  logic [IDX_W-1:0]      pick_idx_s;
  logic                  pick_any_s;

  logic [IDX_W-1:0]      win_idx_s;
  logic                  win_any_s;
  logic                  can_load_s;
  logic                  xfer_s;
  logic                  advance_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic [IDX_W-1:0]      next_ptr_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (bus.in_valid),
    .ptr        (rr_ptr_r),
    .gnt_onehot (pick_onehot_s),
    .gnt_idx    (pick_idx_s),
    .any        (pick_any_s)
  );

`ifdef HS_ARB_PKT_LOCK_EN
  logic             lock_r;
  logic [IDX_W-1:0] lock_idx_r;
  logic             unused_onehot_s;

  assign unused_onehot_s = ^pick_onehot_s;

  // While a packet is open only its owner may be granted, even if it is momentarily idle.
  always_comb begin
    if (lock_r) begin
      win_idx_s = lock_idx_r;
      win_any_s = bus.in_valid[lock_idx_r];
    end else begin
      win_idx_s = pick_idx_s;
      win_any_s = pick_any_s;
    end
  end

  assign advance_s = xfer_s && bus.in_last[win_idx_s];

  // Lock opens on a non-last beat and releases on the owner's last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
    end else if (xfer_s) begin
      lock_r     <= !bus.in_last[win_idx_s];
      lock_idx_r <= win_idx_s;
    end else begin
      lock_r     <= lock_r;
      lock_idx_r <= lock_idx_r;
    end
  end
`else
  logic unused_last_s;
  logic unused_onehot_s;

  assign unused_last_s   = ^bus.in_last;
  assign unused_onehot_s = ^pick_onehot_s;
  assign win_idx_s       = pick_idx_s;
  assign win_any_s       = pick_any_s;
  assign advance_s       = xfer_s;
`endif

  assign can_load_s = !out_valid_r || bus.out_ready;
  assign xfer_s     = can_load_s && win_any_s && !rst;
  assign next_ptr_s = (win_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : (win_idx_s + IDX_W'(1));

  // Grant at most one requester, and only when the output register can take a beat.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i] = xfer_s && (win_idx_s == IDX_W'(i));
    end
  end

  // Payload mux for the winning requester.
  always_comb begin
    data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      data_s = (win_idx_s == IDX_W'(i)) ? bus.in_data[i*DATA_WIDTH +: DATA_WIDTH] : data_s;
    end
  end

  // Output stage: load on transfer, drain on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_src_r   <= '0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= data_s;
      out_src_r   <= win_idx_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_src_r   <= out_src_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_src_r   <= out_src_r;
    end
  end

  // Round-robin pointer moves past the winner; it stays put when nobody transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (advance_s) begin
      rr_ptr_r <= next_ptr_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed self-checking bench for handshake_rr_arbiter (NUM_REQ=4, DATA_WIDTH=32).
module tb_handshake_rr_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] d [0:3];

  handshake_rr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

  handshake_rr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data();
    bus.in_data = {d[3], d[2], d[1], d[0]};
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int src);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_src"},   64'(bus.out_src),   64'(src));
    chk({tag, "_data"},  64'(bus.out_data),  64'(d[src]));
  endtask

  initial begin
    int seq_a [0:3];
    int seq_p [0:3];
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4; i++) d[i] = 32'hC0DE_0000 + 32'(i);
    set_data();
    rst           = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.in_last   = 4'b0000;
    bus.out_ready = 1'b1;

    // Reset held with all requesters valid
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_src",   64'(bus.out_src),   64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    rst = 1'b0;
    #1;

    // Full rotation 0,1,2,3,0 at one beat per cycle
    for (int k = 0; k < 5; k++) begin
      chk("rot_in_ready", 64'(bus.in_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk_beat("rot", k % 4);
    end

    // Sparse requesters 1 and 3 alternate (pointer is at 1)
    bus.in_valid = 4'b1010;
    #1;
    seq_a = '{1, 3, 1, 3};
    for (int k = 0; k < 4; k++) begin
      chk("alt_in_ready", 64'(bus.in_ready), 64'(4'b0001 << seq_a[k]));
      tick();
      chk_beat("alt", seq_a[k]);
    end

    // Backpressure with a held DEADBEEF beat
    d[0] = 32'hDEAD_BEEF;
    set_data();
    bus.in_valid = 4'b0001;
    #1;
    chk("bp_load_ready", 64'(bus.in_ready), 64'b0001);
    tick();
    chk("bp_load_data", 64'(bus.out_data), 64'h0000_0000_DEAD_BEEF);
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0110;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk_beat("bp_hold", 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'b0010);
    tick();
    chk_beat("bp_nobubble", 1);
    bus.in_valid = 4'b0100;
    #1;
    chk("bp_next_ready", 64'(bus.in_ready), 64'b0100);
    tick();
    chk_beat("bp_next", 2);
    bus.in_valid = 4'b0000;
    tick();
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_src",   64'(bus.out_src),   64'd2);
    chk("drain_data",  64'(bus.out_data),  64'(d[2]));
    d[0] = 32'hC0DE_0000;
    set_data();

    // Wrap from 3 to 0, then pointer holds through idle cycles
    bus.in_valid = 4'b1000;
    #1;
    tick();
    chk_beat("wrap", 3);
    bus.in_valid = 4'b0000;
    repeat (5) tick();
    chk("idle_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_ready", 64'(bus.in_ready),  64'd0);
    bus.in_valid = 4'b1001;
    #1;
    chk("hold_ptr_ready", 64'(bus.in_ready), 64'b0001);
    tick();
    chk_beat("hold_ptr", 0);
    bus.in_valid = 4'b1000;
    #1;
    chk("after_hold_ready", 64'(bus.in_ready), 64'b1000);
    tick();
    chk_beat("after_hold", 3);

    // Mid-stream reset: pointer at 1 beforehand, restarts at 0 afterwards
    bus.in_valid = 4'b1111;
    #1;
    tick();
    chk_beat("pre_rst", 0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_src",   64'(bus.out_src),   64'd0);
    chk("midrst_data",  64'(bus.out_data),  64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.in_ready), 64'b0001);
    tick();
    chk_beat("post_rst", 0);

    // Move pointer to 2, then requester 2 sends a three-beat packet against 0 and 1
    bus.in_valid = 4'b0010;
    #1;
    tick();
    chk_beat("pkt_setup", 1);
    bus.in_valid = 4'b0111;
`ifdef HS_ARB_PKT_LOCK_EN
    seq_p = '{2, 2, 2, 0};
`else
    seq_p = '{2, 0, 1, 2};
`endif
    for (int k = 0; k < 4; k++) begin
      bus.in_last = (k == 2) ? 4'b0100 : 4'b0000;
      #1;
      chk("pkt_in_ready", 64'(bus.in_ready), 64'(4'b0001 << seq_p[k]));
      tick();
      chk_beat("pkt", seq_p[k]);
    end
    bus.in_valid = 4'b0000;
    bus.in_last  = 4'b0000;
    tick();
    chk("end_valid", 64'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
